// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset vector, fetch FSM states, word size.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/npc.sv
// Next-PC selection: sequential PC+4 or a prioritised jr > j > branch redirect target.
module npc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        br_taken,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm,
    input  logic        j_taken,
    input  logic [25:0] j_index,
    input  logic        jr_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        jr_misaligned
);

    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_aligned;

    assign br_target  = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    assign j_target   = {br_pc4[31:28], j_index, 2'b00};
    assign jr_aligned = {jr_target[31:2], 2'b00};

    assign redirect      = jr_taken || j_taken || br_taken;
    assign jr_misaligned = jr_taken && (jr_target[1:0] != 2'b00);

    always_comb begin
        next_pc = pc + WORD_BYTES;
        if (jr_taken) begin
            next_pc = jr_aligned;
        end else if (j_taken) begin
            next_pc = j_target;
        end else if (br_taken) begin
            next_pc = br_target;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address, IF/ID register
// with valid/ready handoff to decode, redirect flush and halt.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_data,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_pc4,
    input  logic [15:0]      br_imm,
    input  logic             j_taken,
    input  logic [25:0]      j_index,
    input  logic             jr_taken,
    input  logic [31:0]      jr_target,
    input  logic             halt,
    input  logic             id_ready,
    output logic             if_valid,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc4,
    output logic [31:0]      pc,
    output logic             addr_err,
    output logic             halted
);

    fetch_state_t state, state_nx;

    logic [31:0] next_pc;
    logic        redirect;
    logic        jr_misaligned;
    logic        advance;
    logic        load_pc;
    logic        fetch;
    logic        drop;
    logic        take_redirect;

    npc u_npc (
        .pc            (pc),
        .br_taken      (br_taken),
        .br_pc4        (br_pc4),
        .br_imm        (br_imm),
        .j_taken       (j_taken),
        .j_index       (j_index),
        .jr_taken      (jr_taken),
        .jr_target     (jr_target),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .jr_misaligned (jr_misaligned)
    );

    assign im_addr = pc[IM_AW+1:2];
    assign halted  = (state == HALT);
    assign advance = (!if_valid || id_ready) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        load_pc       = 1'b0;
        fetch         = 1'b0;
        drop          = 1'b0;
        take_redirect = 1'b0;
        case (state)
            BOOT: state_nx = RUN;
            RUN: begin
                if (redirect) begin
                    take_redirect = 1'b1;
                    load_pc       = 1'b1;
                    drop          = 1'b1;
                end else if (halt) begin
                    // The halt cycle itself already stops fetching; only the handoff remains.
                    state_nx = HALT;
                    drop     = if_valid && id_ready;
                end else if (advance) begin
                    fetch   = 1'b1;
                    load_pc = 1'b1;
                end else begin
                    drop = if_valid && id_ready;
                end
            end
            HALT:    drop = if_valid && id_ready;
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc4   <= '0;
            addr_err <= 1'b0;
        end else begin
            if (load_pc) begin
                pc <= next_pc;
            end
            if (fetch) begin
                if_instr <= im_data;
                if_pc4   <= next_pc;
                if_valid <= 1'b1;
            end else if (drop) begin
                if_valid <= 1'b0;
            end
            if (take_redirect && jr_misaligned) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan sequence, then random traffic
// against a cycle-level reference model of the fetch rules.
module tb_if_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam int          TB_IM_AW    = 10;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [TB_IM_AW-1:0] im_addr;
    logic [31:0]         im_data;
    logic                stall, br_taken, j_taken, jr_taken, halt, id_ready;
    logic [31:0]         br_pc4, jr_target;
    logic [15:0]         br_imm;
    logic [25:0]         j_index;
    logic                if_valid, addr_err, halted;
    logic [31:0]         if_instr, if_pc4, pc;

    logic [31:0] mem [0:(1<<TB_IM_AW)-1];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_boot, m_halt, m_valid, m_err;
    logic [31:0] m_pc, m_instr, m_pc4;

    always #5 clk = ~clk;

    assign im_data = mem[im_addr];

    if_stage #(.RESET_PC(TB_RESET_PC), .IM_AW(TB_IM_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .im_addr   (im_addr),
        .im_data   (im_data),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_pc4    (br_pc4),
        .br_imm    (br_imm),
        .j_taken   (j_taken),
        .j_index   (j_index),
        .jr_taken  (jr_taken),
        .jr_target (jr_target),
        .halt      (halt),
        .id_ready  (id_ready),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc4    (if_pc4),
        .pc        (pc),
        .addr_err  (addr_err),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_halt  = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_pc    = TB_RESET_PC;
        m_instr = '0;
        m_pc4   = '0;
    endtask

    // One rising edge worth of fetch-stage behaviour, from the current inputs.
    task automatic model_edge();
        logic [31:0] tgt;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            if (m_valid && id_ready) m_valid = 1'b0;
        end else if (jr_taken || j_taken || br_taken) begin
            if (jr_taken) begin
                tgt = jr_target & 32'hFFFF_FFFC;
                if (jr_target % 4 != 0) m_err = 1'b1;
            end else if (j_taken) begin
                tgt = (br_pc4 & 32'hF000_0000) | ({6'd0, j_index} * 4);
            end else begin
                tgt = br_pc4 + $signed({{16{br_imm[15]}}, br_imm}) * 4;
            end
            m_pc    = tgt;
            m_valid = 1'b0;
        end else if (halt) begin
            m_halt = 1'b1;
            if (m_valid && id_ready) m_valid = 1'b0;
        end else if ((!m_valid || id_ready) && !stall) begin
            m_instr = mem[(m_pc / 4) % (1 << TB_IM_AW)];
            m_pc    = m_pc + 4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
        end else if (m_valid && id_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        check("if_instr", if_instr, m_instr);
        check("if_pc4",   if_pc4,   m_pc4);
        check("pc",       pc,       m_pc);
        check("im_addr",  {22'd0, im_addr}, (m_pc / 4) % (1 << TB_IM_AW));
        check("addr_err", {31'd0, addr_err}, {31'd0, m_err});
        check("halted",   {31'd0, halted},   {31'd0, m_halt});
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_redirects();
        br_taken = 1'b0;
        j_taken  = 1'b0;
        jr_taken = 1'b0;
        halt     = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < (1 << TB_IM_AW); k++) mem[k] = k + 1;
        rst_n = 1'b0;
        stall = 1'b0; id_ready = 1'b1;
        clear_redirects();
        br_pc4 = '0; br_imm = '0; j_index = '0; jr_target = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Boot cycle, then consecutive words
        step();
        check("boot_valid", {31'd0, if_valid}, 32'd0);
        step();
        check("w1_instr", if_instr, 32'd1);
        check("w1_pc4",   if_pc4,   32'd4);

        // Backpressure holds the first word
        id_ready = 1'b0;
        repeat (3) step();
        check("bp_instr", if_instr, 32'd1);
        check("bp_pc",    pc,       32'd4);
        check("bp_addr",  {22'd0, im_addr}, 32'd1);
        id_ready = 1'b1;
        step();
        check("w2_instr", if_instr, 32'd2);
        step();
        check("w3_instr", if_instr, 32'd3);
        check("w3_pc4",   if_pc4,   32'd12);

        // Backward branch to 0
        br_taken = 1'b1; br_pc4 = 32'd8; br_imm = 16'hFFFE;
        step();
        check("br_pc",    pc, 32'd0);
        check("br_flush", {31'd0, if_valid}, 32'd0);
        clear_redirects();
        step();
        check("br_refetch", if_instr, 32'd1);

        // All three redirects at once: jr wins
        jr_taken = 1'b1; jr_target = 32'h40;
        j_taken = 1'b1; j_index = 26'h123; br_taken = 1'b1;
        step();
        check("prio_pc", pc, 32'h40);
        clear_redirects();

        // Misaligned jr is sticky
        jr_taken = 1'b1; jr_target = 32'h23;
        step();
        check("mis_pc",  pc, 32'h20);
        check("mis_err", {31'd0, addr_err}, 32'd1);
        clear_redirects();
        repeat (10) step();
        check("mis_sticky", {31'd0, addr_err}, 32'd1);

        // Halt with a valid word being handed off
        check("pre_halt_valid", {31'd0, if_valid}, 32'd1);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halted", {31'd0, halted}, 32'd1);
        check("halt_valid", {31'd0, if_valid}, 32'd0);
        br_taken = 1'b1; br_pc4 = 32'h100; br_imm = 16'h0010;
        repeat (3) step();
        check("halt_pc_frozen", pc, m_pc);
        clear_redirects();
        apply_reset();
        check("rst_pc", pc, TB_RESET_PC);

        // Random traffic with occasional asynchronous resets
        for (int n = 0; n < 4000; n++) begin
            if (n % 700 == 699) begin
                apply_reset();
            end else begin
                stall     = ($urandom % 4) == 0;
                id_ready  = ($urandom % 4) != 0;
                br_taken  = ($urandom % 12) == 0;
                j_taken   = ($urandom % 24) == 0;
                jr_taken  = ($urandom % 24) == 0;
                halt      = ($urandom % 300) == 0;
                br_pc4    = $urandom;
                br_imm    = 16'($urandom);
                j_index   = 26'($urandom);
                jr_target = $urandom;
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS core, directly upstream of the instruction memory.
- Owns the PC register and computes the next PC: sequential, branch, jump or jump-register.
- Drives the word address into the instruction memory and captures the returned word into an IF/ID output register.
- Uses a valid/ready handshake to decode and flushes on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IM_AW, 10, instruction-memory word-address width (the address is PC[IM_AW+1:2]).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- im_addr  out  IM_AW  word address to instruction memory, equal to pc[IM_AW+1:2], combinational from the PC register
- im_data  in  32  instruction word returned combinationally by the instruction memory
- stall  in  1  global freeze from the hazard unit
- br_taken  in  1  branch redirect request
- br_pc4  in  32  PC+4 of the branch instruction
- br_imm  in  16  branch immediate
- j_taken  in  1  j/jal redirect request
- j_index  in  26  jump index field
- jr_taken  in  1  jr/jalr redirect request
- jr_target  in  32  register jump target
- halt  in  1  stop fetching (e.g. syscall/break detected)
- id_ready  in  1  decode accepts the IF/ID word this cycle
- if_valid  out  1  IF/ID register holds a valid instruction
- if_instr  out  32  fetched instruction
- if_pc4  out  32  PC+4 of the fetched instruction
- pc  out  32  current PC register
- addr_err  out  1  sticky flag: misaligned jr_target seen
- halted  out  1  stage is in HALT

Behaviour:
- Reset (async, rst_n=0), all outputs:
  - pc=RESET_PC
  - if_valid=0
  - if_instr=0
  - if_pc4=0
  - addr_err=0
  - halted=0
  - FSM=BOOT
- BOOT lasts exactly one cycle after rst_n deasserts: no fetch, then go to RUN. This gives the memory one cycle of settled address.
- RUN:
  - advance = (!if_valid || id_ready) && !stall.
  - On advance: if_instr<=im_data, if_pc4<=pc+4, if_valid<=1, pc<=pc+4.
  - Latency: a word is visible on if_instr one cycle after its PC is on im_addr.
  - If if_valid && !id_ready && !stall: hold pc and the IF/ID register unchanged.
  - If !advance and id_ready && if_valid, i.e. only because of stall: the word is consumed, so if_valid<=0.
- Redirect:
  - Priority is jr_taken > j_taken > br_taken. A redirect overrides stall and backpressure.
  - Targets:
    - branch: br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00}, modulo 2^32
    - jump: {br_pc4[31:28], j_index, 2'b00}. Jumps reuse the br_pc4 bus as the delay-free pc4 source, and the decoder drives it for jumps.
    - jr: {jr_target[31:2], 2'b00}
  - Effect on the next edge: pc<=target and if_valid<=0 (flush the wrong-path word). The next fetch is from the target.
- Misalignment: jr_taken with jr_target[1:0]!=0 sets addr_err=1. It stays set until reset, and the redirect still proceeds with the low bits cleared.
- Wrap-around: pc+4 wraps modulo 2^32. im_addr wraps every 4 KB because only pc[11:2] is driven.
- HALT:
  - halt=1 in RUN, with no redirect, moves the FSM to HALT on the next edge. halted=1.
  - pc is frozen and no new fetches occur.
  - Any valid word is still handed off when id_ready; after that if_valid stays 0.
  - Redirects in HALT are ignored. Only reset exits HALT.
  - halt and a redirect in the same cycle: the redirect is applied, and HALT is entered on the next cycle if halt is still high.
- Reset mid-operation clears everything asynchronously, including a pending IF/ID word.

Decomposition:
- Shared package mips_pkg:
  - RESET_PC default
  - FSM state enum {BOOT, RUN, HALT}
  - word-size constant 4
- Sub-module npc (combinational):
  - inputs: pc, the redirect requests and operands
  - outputs: next_pc and redirect flag
  - implements the priority and target arithmetic above

Test Plan:
- Reset release, id_ready=1, memory word k = k+1: cycle 1 if_valid=0. Then if_instr=1, 2, 3 on consecutive cycles, with if_pc4=4, 8, 12.
- id_ready=0 for 3 cycles after the first word: if_instr holds 1, pc holds 4 and im_addr=1. Releasing id_ready resumes with word 2.
- Branch: br_taken with br_pc4=8 and br_imm=16'hFFFE (-2). Next pc=0 and if_valid=0 for one cycle; word 1 is fetched again.
- Same cycle jr_taken (jr_target=32'h40), j_taken and br_taken: pc=32'h40 and the jr path is taken.
- jr_target=32'h23: pc=32'h20 and addr_err=1, still 1 after 10 further cycles.
- halt pulse while if_valid=1 and id_ready=1: halted=1, pc frozen, if_valid=0 after the handoff. br_taken is then ignored, and rst_n=0 returns pc=RESET_PC.
